ordered_merge: RTL and testbench

ORDERED_MERGE -- requirements
Module: ordered_merge

---
 rtl/ordered_merge_pkg.sv | 20 ++
 rtl/ordered_merge_if.sv | 17 +
 rtl/axis_fifo.sv | 68 ++++++
 rtl/ordered_merge.sv | 114 +++++++++++
 tb/tb_ordered_merge.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ordered_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ordered_merge_pkg
// Description : Token encoding and counter types shared by the ordered merge.
// Revision    : 1.0
// ============================================================================
package ordered_merge_pkg;

    localparam logic TOK_TRUE  = 1'b1;
    localparam logic TOK_FALSE = 1'b0;
    localparam int   CNT_WIDTH = 16;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    function automatic logic tok_selects_true(input logic tok);
        return tok == TOK_TRUE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ordered_merge_if.sv
`default_nettype none
// ============================================================================
// Module      : ordered_merge_if
// Description : Minimal AXI-Stream style valid/ready/data bundle.
// Revision    : 1.0
// ============================================================================
interface ordered_merge_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo
// Description : Synchronous stream FIFO, power-of-two depth, no sideband.
// Revision    : 1.0
// ============================================================================
module axis_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  wire logic                         s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  wire logic                         m_axis_tready,
    output logic [$clog2(DEPTH+1)-1:0]        count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    // Ready depends on the stored count only, so a same-cycle pop never frees a slot early.
    assign s_axis_tready = (r_count != CW'(DEPTH));
    assign m_axis_tvalid = (r_count != '0);
    assign m_axis_tdata  = r_mem[r_rd_ptr];
    assign count         = r_count;

    assign w_push = s_axis_tvalid && s_axis_tready;
    assign w_pop  = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ordered_merge.sv
`default_nettype none
// ============================================================================
// Module      : ordered_merge
// Description : Merges two value streams in the order dictated by a token stream.
// Revision    : 1.0
// ============================================================================
module ordered_merge
    import ordered_merge_pkg::*;
#(
    parameter int VAL_WIDTH   = 16,
    parameter int FIFO_SIZE   = 16,
    parameter int STALL_LIMIT = 1024
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    ordered_merge_if.slave                    s_cond_axis,
    ordered_merge_if.slave                    s_true_val_axis,
    ordered_merge_if.slave                    s_false_val_axis,
    ordered_merge_if.master                   m_val_axis,
    output logic [$clog2(FIFO_SIZE+1)-1:0]    pending_cnt,
    output cnt_t                              true_cnt,
    output cnt_t                              false_cnt,
    output logic                              stall_err
);

    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic                 w_fifo_in_ready;
    logic                 w_fifo_in_valid;
    logic [0:0]           w_tok_data;
    logic                 w_tok_v;
    logic                 w_tok;
    logic                 w_out_free;
    logic                 w_sel_valid;
    logic [VAL_WIDTH-1:0] w_sel_data;
    logic                 w_fire;
    logic                 w_stall;

    logic [VAL_WIDTH-1:0] r_out_data;
    logic                 r_out_valid;
    logic [SW-1:0]        r_stall_cnt;

    assign w_fifo_in_valid   = s_cond_axis.tvalid && !rst;
    assign s_cond_axis.tready = w_fifo_in_ready && !rst;

    axis_fifo #(
        .DATA_WIDTH (1),
        .DEPTH      (FIFO_SIZE)
    ) u_tok_fifo (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_cond_axis.tdata),
        .s_axis_tvalid (w_fifo_in_valid),
        .s_axis_tready (w_fifo_in_ready),
        .m_axis_tdata  (w_tok_data),
        .m_axis_tvalid (w_tok_v),
        .m_axis_tready (w_fire),
        .count         (pending_cnt)
    );

    assign w_tok       = w_tok_data[0];
    assign w_out_free  = !r_out_valid || m_val_axis.tready;
    assign w_sel_valid = tok_selects_true(w_tok) ? s_true_val_axis.tvalid : s_false_val_axis.tvalid;
    assign w_sel_data  = tok_selects_true(w_tok) ? s_true_val_axis.tdata  : s_false_val_axis.tdata;
    assign w_fire      = w_tok_v && w_sel_valid && w_out_free;
    assign w_stall     = w_tok_v && !w_sel_valid;

    // Only the stream named by the head token may ever see ready.
    assign s_true_val_axis.tready  = w_tok_v && (w_tok == TOK_TRUE)  && w_out_free;
    assign s_false_val_axis.tready = w_tok_v && (w_tok == TOK_FALSE) && w_out_free;

    assign m_val_axis.tdata  = r_out_data;
    assign m_val_axis.tvalid = r_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            true_cnt    <= '0;
            false_cnt   <= '0;
        end else begin
            if (w_fire) begin
                r_out_data  <= w_sel_data;
                r_out_valid <= 1'b1;
                if (tok_selects_true(w_tok)) begin
                    true_cnt <= true_cnt + cnt_t'(1);
                end else begin
                    false_cnt <= false_cnt + cnt_t'(1);
                end
            end else if (m_val_axis.tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Back-pressure from the output alone is not a stall: the count just holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            stall_err   <= 1'b0;
        end else begin
            if (w_fire || !w_tok_v) begin
                r_stall_cnt <= '0;
            end else if (w_stall && (r_stall_cnt != SW'(STALL_LIMIT))) begin
                r_stall_cnt <= r_stall_cnt + SW'(1);
                if (r_stall_cnt == SW'(STALL_LIMIT - 1)) begin
                    stall_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ordered_merge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ordered_merge
// Description : Directed self-checking bench for ordered_merge.
// Revision    : 1.0
// ============================================================================
module tb_ordered_merge;

    localparam int CH_COND  = 0;
    localparam int CH_TRUE  = 1;
    localparam int CH_FALSE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  pending_cnt;
    logic [15:0] true_cnt;
    logic [15:0] false_cnt;
    logic        stall_err;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    logic [15:0] got[$];
    int unsigned got_cyc[$];

    ordered_merge_if #(.WIDTH(1))  cond_if ();
    ordered_merge_if #(.WIDTH(16)) true_if ();
    ordered_merge_if #(.WIDTH(16)) false_if ();
    ordered_merge_if #(.WIDTH(16)) out_if ();

    ordered_merge #(
        .VAL_WIDTH   (16),
        .FIFO_SIZE   (16),
        .STALL_LIMIT (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_cond_axis      (cond_if),
        .s_true_val_axis  (true_if),
        .s_false_val_axis (false_if),
        .m_val_axis       (out_if),
        .pending_cnt      (pending_cnt),
        .true_cnt         (true_cnt),
        .false_cnt        (false_cnt),
        .stall_err        (stall_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_if.tvalid && out_if.tready) begin
            got.push_back(out_if.tdata);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] beat(input int i);
        if (i < got.size()) return {16'h0, got[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic send(input int ch, input logic [15:0] d);
        logic hs;
        hs = 1'b0;
        case (ch)
            CH_COND:  begin cond_if.tdata  = d[0]; cond_if.tvalid  = 1'b1; end
            CH_TRUE:  begin true_if.tdata  = d;    true_if.tvalid  = 1'b1; end
            default:  begin false_if.tdata = d;    false_if.tvalid = 1'b1; end
        endcase
        for (int n = 0; n < 100 && !hs; n++) begin
            @(negedge clk);
            hs = (ch == CH_COND) ? cond_if.tready :
                 (ch == CH_TRUE) ? true_if.tready : false_if.tready;
            @(posedge clk);
            #1;
        end
        case (ch)
            CH_COND:  cond_if.tvalid  = 1'b0;
            CH_TRUE:  true_if.tvalid  = 1'b0;
            default:  false_if.tvalid = 1'b0;
        endcase
        if (!hs) check($sformatf("send_ch%0d_timeout", ch), 32'(hs), 32'd1);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        cond_if.tvalid  = 1'b0;
        true_if.tvalid  = 1'b0;
        false_if.tvalid = 1'b0;
        out_if.tready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        got.delete();
        got_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        cond_if.tdata = '0;  cond_if.tvalid  = 1'b0;
        true_if.tdata = '0;  true_if.tvalid  = 1'b0;
        false_if.tdata = '0; false_if.tvalid = 1'b0;
        out_if.tready = 1'b0;

        // Reset state, including tready held low while rst is asserted.
        repeat (2) @(posedge clk);
        #1;
        check("rst_cond_rdy", 32'(cond_if.tready), 32'd0);
        do_reset();
        check("rst_pending", 32'(pending_cnt), 32'd0);
        check("rst_tvalid", 32'(out_if.tvalid), 32'd0);
        check("rst_tdata", 32'(out_if.tdata), 32'd0);
        check("rst_true_cnt", 32'(true_cnt), 32'd0);
        check("rst_false_cnt", 32'(false_cnt), 32'd0);
        check("rst_stall_err", 32'(stall_err), 32'd0);
        check("rst_cond_rdy_after", 32'(cond_if.tready), 32'd1);

        // Basic interleaved merge: tokens 1,0,1.
        out_if.tready = 1'b1;
        fork
            begin send(CH_COND, 16'd1); send(CH_COND, 16'd0); send(CH_COND, 16'd1); end
            begin send(CH_TRUE, 16'h0011); send(CH_TRUE, 16'h0033); end
            begin send(CH_FALSE, 16'h0022); end
        join
        repeat (3) @(posedge clk);
        #1;
        check("t1_nbeats", 32'(got.size()), 32'd3);
        check("t1_beat0", beat(0), 32'h0011);
        check("t1_beat1", beat(1), 32'h0022);
        check("t1_beat2", beat(2), 32'h0033);
        check("t1_true_cnt", 32'(true_cnt), 32'd2);
        check("t1_false_cnt", 32'(false_cnt), 32'd1);
        check("t1_pending", 32'(pending_cnt), 32'd0);

        // Waiting false beat must not bypass a head token of 1.
        do_reset();
        out_if.tready   = 1'b1;
        false_if.tdata  = 16'h00AA;
        false_if.tvalid = 1'b1;
        send(CH_COND, 16'd1);
        send(CH_COND, 16'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t2_false_rdy_%0d", i), 32'(false_if.tready), 32'd0);
            @(posedge clk);
            #1;
        end
        check("t2_no_out", 32'(got.size()), 32'd0);
        check("t2_pending", 32'(pending_cnt), 32'd2);
        send(CH_TRUE, 16'h00BB);
        @(negedge clk);
        check("t2_false_rdy_go", 32'(false_if.tready), 32'd1);
        @(posedge clk);
        #1;
        false_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t2_nbeats", 32'(got.size()), 32'd2);
        check("t2_beat0", beat(0), 32'h00BB);
        check("t2_beat1", beat(1), 32'h00AA);

        // Full token FIFO: ready low at 16 entries, back high after one fire.
        do_reset();
        out_if.tready = 1'b1;
        for (int i = 0; i < 16; i++) send(CH_COND, 16'd1);
        check("t3_pending_full", 32'(pending_cnt), 32'd16);
        check("t3_cond_rdy_full", 32'(cond_if.tready), 32'd0);
        send(CH_TRUE, 16'h0055);
        check("t3_pending_pop", 32'(pending_cnt), 32'd15);
        check("t3_cond_rdy_pop", 32'(cond_if.tready), 32'd1);

        // Output back-pressure holds the beat, then full-rate streaming.
        do_reset();
        for (int i = 0; i < 5; i++) send(CH_COND, 16'd1);
        send(CH_TRUE, 16'h1234);
        true_if.tdata  = 16'h2000;
        true_if.tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t4_hold_data_%0d", i), 32'(out_if.tdata), 32'h1234);
            check($sformatf("t4_hold_valid_%0d", i), 32'(out_if.tvalid), 32'd1);
            check($sformatf("t4_true_rdy_%0d", i), 32'(true_if.tready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) send(CH_TRUE, 16'h2000 + 16'(i));
        repeat (2) @(posedge clk);
        #1;
        check("t4_nbeats", 32'(got.size()), 32'd5);
        check("t4_beat0", beat(0), 32'h1234);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("t4_beat%0d", i), beat(i), 32'h2000 + 32'(i - 1));
            if (i < got_cyc.size())
                check($sformatf("t4_gap%0d", i), got_cyc[i] - got_cyc[i-1], 32'd1);
        end

        // Watchdog: stall_err on the 4th stall cycle, sticky through a merge.
        do_reset();
        out_if.tready = 1'b1;
        send(CH_COND, 16'd1);
        check("t5_err_start", 32'(stall_err), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("t5_err_cyc%0d", k), 32'(stall_err), (k == 4) ? 32'd1 : 32'd0);
        end
        send(CH_TRUE, 16'h0077);
        repeat (2) @(posedge clk);
        #1;
        check("t5_beat0", beat(0), 32'h0077);
        check("t5_err_sticky", 32'(stall_err), 32'd1);
        check("t5_true_cnt", 32'(true_cnt), 32'd1);
        do_reset();
        check("t5_err_cleared", 32'(stall_err), 32'd0);

        // No token bypass and one-cycle fire-to-valid latency.
        out_if.tready  = 1'b1;
        true_if.tdata  = 16'h0099;
        true_if.tvalid = 1'b1;
        cond_if.tdata  = 1'b1;
        cond_if.tvalid = 1'b1;
        @(negedge clk);
        check("t6_no_bypass", 32'(true_if.tready), 32'd0);
        check("t6_cond_rdy", 32'(cond_if.tready), 32'd1);
        @(posedge clk);
        #1;
        cond_if.tvalid = 1'b0;
        @(negedge clk);
        check("t6_true_rdy", 32'(true_if.tready), 32'd1);
        check("t6_not_yet", 32'(out_if.tvalid), 32'd0);
        @(posedge clk);
        #1;
        true_if.tvalid = 1'b0;
        check("t6_lat_valid", 32'(out_if.tvalid), 32'd1);
        check("t6_lat_data", 32'(out_if.tdata), 32'h0099);

        // Asynchronous reset mid-stream with tokens queued and a held beat.
        do_reset();
        for (int i = 0; i < 4; i++) send(CH_COND, 16'd1);
        send(CH_TRUE, 16'h0011);
        check("t7_pending_pre", 32'(pending_cnt), 32'd3);
        check("t7_valid_pre", 32'(out_if.tvalid), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t7_pending_rst", 32'(pending_cnt), 32'd0);
        check("t7_valid_rst", 32'(out_if.tvalid), 32'd0);
        check("t7_data_rst", 32'(out_if.tdata), 32'd0);
        check("t7_true_cnt_rst", 32'(true_cnt), 32'd0);
        check("t7_cond_rdy_rst", 32'(cond_if.tready), 32'd0);
        check("t7_true_rdy_rst", 32'(true_if.tready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        got.delete();
        got_cyc.delete();
        out_if.tready = 1'b1;
        fork
            send(CH_COND, 16'd0);
            send(CH_FALSE, 16'h0042);
        join
        repeat (3) @(posedge clk);
        #1;
        check("t7_nbeats", 32'(got.size()), 32'd1);
        check("t7_beat0", beat(0), 32'h0042);
        check("t7_false_cnt", 32'(false_cnt), 32'd1);
        check("t7_true_cnt", 32'(true_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
